mem_request_responder: RTL and testbench
========================================

Name: mem_request_responder

Overview:
- Responder end of the datapath's memory request interface: accepts the dREN/dWEN data requests produced by instruction decode and the iREN fetch requests, and arbitrates them onto a single RAM port.
- Holds the requester with iwait/dwait until the RAM reports ACCESS, then returns load data for exactly one cycle.
- Sits between the pipeline's fetch/memory stages and the RAM model; data requests take priority over fetch.

Parameters:
- TIMEOUT, 15, max cycles spent in a RAM access state before forcing an error response (>=1)
- ERR_WORD, 32'hBAD1BAD1, load value returned on an error response

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  instruction fetch request
- iaddr  input  32  fetch address
- iwait  output  1  fetch stall; 0 only in the fetch response cycle
- iload  output  32  fetched instruction (registered)
- dREN  input  1  data read request
- dWEN  input  1  data write request
- daddr  input  32  data address
- dstore  input  32  write data
- dwait  output  1  data stall; 0 only in the data response cycle
- dload  output  32  read data (registered)
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data, valid when ramstate==ACCESS
- ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- mem_err  output  1  sticky error flag

Behaviour:
- Reset (async, nRST=0):
  - State IDLE; counter 0.
  - ramREN, ramWEN, ramaddr, ramstore, iload, dload, mem_err all 0.
  - RAM strobes drop in the same cycle reset asserts; a RAM operation interrupted by reset is abandoned.
- States: IDLE, DACC, IACC, DRESP, IRESP.
- IDLE:
  - dREN|dWEN goes to DACC: latch daddr, dstore, and op (write if dWEN, read otherwise).
  - Otherwise iREN goes to IACC: latch iaddr.
  - Otherwise stay in IDLE.
  - No RAM strobes in IDLE.
- DACC/IACC:
  - Drive ramaddr/ramstore from the latched registers. ramREN=1 for reads/fetch; ramWEN=1 for writes. Never both.
  - Counter increments every cycle in the state.
  - ramstate==ACCESS: capture ramload into dload (DACC read) or iload (IACC); go to DRESP/IRESP. Writes leave dload unchanged.
  - ramstate==ERROR, or counter reaches TIMEOUT: load ERR_WORD into dload/iload, set mem_err, go to DRESP/IRESP.
  - FREE/BUSY: stay.
- DRESP/IRESP:
  - One cycle only; strobes 0; counter cleared; return to IDLE.
- Wait outputs (combinational):
  - dwait = (dREN|dWEN) & (state!=DRESP).
  - iwait = iREN & (state!=IRESP).
- Latency: with ramstate==ACCESS on the first access cycle, the request seen in IDLE at cycle 0 gives the response at cycle 2. Back-to-back requests complete every 3 cycles.
- Priority: simultaneous data and fetch requests in IDLE serve data first. The fetch keeps iwait=1 and is served in a later IDLE.
- dREN and dWEN both high: treated as a write.
- Request withdrawn mid-access: the access still completes (a write is never aborted). The response cycle still occurs, with wait outputs 0.
- Latched address/data are not updated while in an access state, even if the inputs change.
- mem_err stays 1 until reset. Later requests are still serviced normally.
- Counter width is $clog2(TIMEOUT+1); it never wraps.

Test Plan:
- Reset mid-write: dWEN=1, daddr=0x40, then nRST=0 while in DACC -> ramWEN=0 immediately; after reset release with no requests, state IDLE and all outputs 0.
- Read: dREN=1, daddr=0x100, ramstate BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x100 for 3 cycles; dwait=0 for exactly one cycle with dload=0xDEADBEEF.
- Write: dWEN=1, daddr=0x204, dstore=0x12345678, ramstate=ACCESS on the first cycle -> ramWEN=1 for one cycle, ramstore=0x12345678; dwait falls at cycle 2; dload unchanged.
- Contention: iREN=1 (iaddr=0x0) and dREN=1 (daddr=0x80) together, ramstate=ACCESS -> data served first, with dwait low at cycle 2; iwait held high until its response cycle at cycle 5 (iload=ramload).
- Timeout: iREN=1, ramstate stuck BUSY, TIMEOUT=15 -> after 15 access cycles, iload=0xBAD1BAD1, iwait=0 for one cycle, mem_err=1 and stays 1 through a subsequent successful read.
- RAM error: dREN=1, ramstate=ERROR on the first access cycle -> dload=0xBAD1BAD1, mem_err=1, return to IDLE.

Source files
------------

// File: rtl/mem_request_responder.sv
// Memory request responder: arbitrates data (priority) and fetch requests onto one RAM port,
// stalling the requester until the RAM answers, times out, or reports an error.
module mem_request_responder #(
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LastCnt = CW'(TIMEOUT - 1);
    localparam logic [1:0] RamAccess = 2'd2;
    localparam logic [1:0] RamError  = 2'd3;

    typedef enum logic [2:0] {StIdle, StDacc, StIacc, StDresp, StIresp} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   store_q, store_d;
    logic          wr_q, wr_d;
    logic [31:0]   iload_q, iload_d;
    logic [31:0]   dload_q, dload_d;
    logic          err_q, err_d;
    logic          in_acc;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            count_q <= '0;
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wr_q    <= wr_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        store_d = store_q;
        wr_d    = wr_q;
        iload_d = iload_q;
        dload_d = dload_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (dREN | dWEN) begin
                    state_d = StDacc;
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
                end else if (iREN) begin
                    state_d = StIacc;
                    addr_d  = iaddr;
                    wr_d    = 1'b0;
                end
            end
            StDacc, StIacc: begin
                // Leaves the state on the TIMEOUT-th cycle, so the counter tops out at TIMEOUT.
                count_d = count_q + CW'(1);
                if (ramstate == RamAccess) begin
                    if (state_q == StDacc) begin
                        if (!wr_q) dload_d = ramload;
                        state_d = StDresp;
                    end else begin
                        iload_d = ramload;
                        state_d = StIresp;
                    end
                end else if (ramstate == RamError || count_q == LastCnt) begin
                    err_d = 1'b1;
                    if (state_q == StDacc) begin
                        dload_d = ERR_WORD;
                        state_d = StDresp;
                    end else begin
                        iload_d = ERR_WORD;
                        state_d = StIresp;
                    end
                end
            end
            StDresp, StIresp: begin
                state_d = StIdle;
                count_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_acc   = (state_q == StDacc) || (state_q == StIacc);
    assign ramREN   = (state_q == StIacc) || ((state_q == StDacc) && !wr_q);
    assign ramWEN   = (state_q == StDacc) && wr_q;
    assign ramaddr  = in_acc ? addr_q : '0;
    assign ramstore = ramWEN ? store_q : '0;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign mem_err  = err_q;
    assign dwait    = (dREN | dWEN) && (state_q != StDresp);
    assign iwait    = iREN && (state_q != StIresp);

endmodule

// File: tb/tb_mem_request_responder.sv
// Directed bench for mem_request_responder: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_mem_request_responder;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] Free = 2'd0, Busy = 2'd1, Access = 2'd2, Error = 2'd3;

    mem_request_responder #(.TIMEOUT(15), .ERR_WORD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the sampling point of the current cycle.
    task automatic sample();
        @(negedge CLK);
    endtask

    // Advance to the drive point of the next cycle.
    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = Free;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 0;
        next();
        next();
        nRST = 1;
    endtask

    int ren_cycles;

    initial begin
        idle_inputs();
        nRST = 0;
        sample();
        check("rst_ramREN", 32'(ramREN), 0);
        check("rst_ramWEN", 32'(ramWEN), 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_iload", iload, 0);
        check("rst_dload", dload, 0);
        check("rst_mem_err", 32'(mem_err), 0);
        next();
        nRST = 1;

        // Reset mid-write
        dWEN = 1; daddr = 32'h40; dstore = 32'h55; ramstate = Busy;
        sample();
        check("rw_idle_ramWEN", 32'(ramWEN), 0);
        check("rw_idle_dwait", 32'(dwait), 1);
        next();
        sample();
        check("rw_acc_ramWEN", 32'(ramWEN), 1);
        check("rw_acc_ramaddr", ramaddr, 32'h40);
        #2 nRST = 0;
        #1;
        check("rw_async_ramWEN", 32'(ramWEN), 0);
        check("rw_async_ramaddr", ramaddr, 0);
        idle_inputs();
        next();
        next();
        nRST = 1;
        sample();
        check("rw_post_ramWEN", 32'(ramWEN), 0);
        check("rw_post_ramstore", ramstore, 0);
        check("rw_post_dwait", 32'(dwait), 0);
        next();
        sample();
        check("rw_post2_ramREN", 32'(ramREN), 0);
        check("rw_post2_ramWEN", 32'(ramWEN), 0);
        next();

        // Read with two BUSY cycles
        dREN = 1; daddr = 32'h100; ramstate = Busy;
        sample();
        check("rd_c0_ramREN", 32'(ramREN), 0);
        check("rd_c0_dwait", 32'(dwait), 1);
        next();
        sample();
        check("rd_c1_ramREN", 32'(ramREN), 1);
        check("rd_c1_ramaddr", ramaddr, 32'h100);
        next();
        sample();
        check("rd_c2_ramREN", 32'(ramREN), 1);
        check("rd_c2_dwait", 32'(dwait), 1);
        next();
        ramstate = Access; ramload = 32'hDEADBEEF;
        sample();
        check("rd_c3_ramREN", 32'(ramREN), 1);
        check("rd_c3_ramaddr", ramaddr, 32'h100);
        next();
        sample();
        check("rd_c4_dwait", 32'(dwait), 0);
        check("rd_c4_dload", dload, 32'hDEADBEEF);
        check("rd_c4_ramREN", 32'(ramREN), 0);
        next();
        dREN = 0;

        // Write, ACCESS on first access cycle
        dWEN = 1; daddr = 32'h204; dstore = 32'h12345678; ramstate = Access; ramload = 32'h0;
        sample();
        check("wr_c0_ramWEN", 32'(ramWEN), 0);
        next();
        sample();
        check("wr_c1_ramWEN", 32'(ramWEN), 1);
        check("wr_c1_ramREN", 32'(ramREN), 0);
        check("wr_c1_ramstore", ramstore, 32'h12345678);
        check("wr_c1_ramaddr", ramaddr, 32'h204);
        check("wr_c1_dwait", 32'(dwait), 1);
        next();
        sample();
        check("wr_c2_dwait", 32'(dwait), 0);
        check("wr_c2_ramWEN", 32'(ramWEN), 0);
        check("wr_c2_dload", dload, 32'hDEADBEEF);
        next();
        dWEN = 0;

        // dREN and dWEN together behave as a write
        dREN = 1; dWEN = 1; daddr = 32'h8; dstore = 32'h77;
        next();
        sample();
        check("both_ramWEN", 32'(ramWEN), 1);
        check("both_ramREN", 32'(ramREN), 0);
        next();
        dREN = 0; dWEN = 0;
        sample();
        check("both_resp_dwait", 32'(dwait), 0);
        next();

        // Contention: data first, fetch afterwards
        iREN = 1; iaddr = 32'h0; dREN = 1; daddr = 32'h80;
        ramstate = Access; ramload = 32'hAAAA0001;
        next();
        sample();
        check("ct_c1_ramaddr", ramaddr, 32'h80);
        check("ct_c1_ramREN", 32'(ramREN), 1);
        check("ct_c1_iwait", 32'(iwait), 1);
        next();
        sample();
        check("ct_c2_dwait", 32'(dwait), 0);
        check("ct_c2_dload", dload, 32'hAAAA0001);
        check("ct_c2_iwait", 32'(iwait), 1);
        next();
        dREN = 0; ramload = 32'hCAFE0002;
        sample();
        check("ct_c3_iwait", 32'(iwait), 1);
        check("ct_c3_ramREN", 32'(ramREN), 0);
        next();
        sample();
        check("ct_c4_ramREN", 32'(ramREN), 1);
        check("ct_c4_ramaddr", ramaddr, 32'h0);
        check("ct_c4_iwait", 32'(iwait), 1);
        next();
        sample();
        check("ct_c5_iwait", 32'(iwait), 0);
        check("ct_c5_iload", iload, 32'hCAFE0002);
        next();
        iREN = 0;

        // Timeout on a fetch stuck BUSY
        iREN = 1; iaddr = 32'h300; ramstate = Busy;
        ren_cycles = 0;
        next();
        for (int i = 0; i < 15; i++) begin
            sample();
            if (ramREN && iwait) ren_cycles++;
            if (i == 14) check("to_err_before", 32'(mem_err), 0);
            next();
        end
        check("to_acc_cycles", 32'(ren_cycles), 15);
        sample();
        check("to_iwait", 32'(iwait), 0);
        check("to_iload", iload, 32'hBAD1BAD1);
        check("to_mem_err", 32'(mem_err), 1);
        check("to_ramREN", 32'(ramREN), 0);
        next();
        iREN = 0;

        // Successful read after error: mem_err stays set
        dREN = 1; daddr = 32'h10; ramstate = Access; ramload = 32'h600D600D;
        next();
        next();
        sample();
        check("ok_dwait", 32'(dwait), 0);
        check("ok_dload", dload, 32'h600D600D);
        check("ok_mem_err", 32'(mem_err), 1);
        next();
        dREN = 0;

        // RAM error response from a clean reset
        do_reset();
        sample();
        check("re_err_clear", 32'(mem_err), 0);
        next();
        dREN = 1; daddr = 32'h20; ramstate = Error; ramload = 32'h11111111;
        next();
        sample();
        check("re_c1_ramREN", 32'(ramREN), 1);
        next();
        sample();
        check("re_c2_dwait", 32'(dwait), 0);
        check("re_c2_dload", dload, 32'hBAD1BAD1);
        check("re_c2_mem_err", 32'(mem_err), 1);
        next();
        dREN = 0;
        next();
        sample();
        check("re_idle_ramREN", 32'(ramREN), 0);
        check("re_idle_ramWEN", 32'(ramWEN), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
